// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises inst/data requests onto a byte-wide memory.
// Define MEM_ARBITER_RR_EN for round-robin on simultaneous requests.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 17,
  parameter int LEN        = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  inst_req,
  input  logic [ADDR_WIDTH-1:0] inst_addr,
  output logic [LEN-1:0]        inst_rdata,
  output logic                  inst_done,
  input  logic                  data_req,
  input  logic                  data_we,
  input  logic [1:0]            data_size,
  input  logic [ADDR_WIDTH-1:0] data_addr,
  input  logic [LEN-1:0]        data_wdata,
  output logic [LEN-1:0]        data_rdata,
  output logic                  data_done,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_e;

  state_e                state_q, state_d;
  logic [2:0]            cnt_q, cnt_d;
  logic [2:0]            n_q, n_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic                  src_q, src_d;
  logic [LEN-1:0]        wdata_q, wdata_d;
  logic [LEN-1:0]        asm_q, asm_d;
  logic [LEN-1:0]        inst_rdata_q, inst_rdata_d;
  logic [LEN-1:0]        data_rdata_q, data_rdata_d;
  logic                  inst_done_q, inst_done_d;
  logic                  data_done_q, data_done_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]            mem_wdata_q, mem_wdata_d;
  logic                  pick_data;
  logic [2:0]            cnt_m1;
  logic [2:0]            n_m1;

  assign cnt_m1 = cnt_q - 3'd1;
  assign n_m1   = n_q - 3'd1;

  function automatic logic [2:0] size_bytes(input logic [1:0] s);
    unique case (s)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

`ifdef MEM_ARBITER_RR_EN
  logic last_q, last_d;

  assign pick_data = data_req & (~inst_req | ~last_q);
  assign last_d    = (state_q == IDLE && (inst_req || data_req))
                   ? pick_data : last_q;

  // Last-grant flag: 1 = data won the previous grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b0;
    else        last_q <= last_d;
  end
`else
  assign pick_data = data_req;
`endif

  // Next-state, byte sequencing and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    n_d          = n_q;
    addr_d       = addr_q;
    we_d         = we_q;
    src_d        = src_q;
    wdata_d      = wdata_q;
    asm_d        = asm_q;
    inst_rdata_d = inst_rdata_q;
    data_rdata_d = data_rdata_q;
    inst_done_d  = 1'b0;
    data_done_d  = 1'b0;
    mem_en_d     = 1'b0;
    mem_we_d     = 1'b0;
    mem_addr_d   = '0;
    mem_wdata_d  = '0;
    unique case (state_q)
      IDLE: begin
        if (inst_req || data_req) begin
          state_d     = XFER;
          cnt_d       = '0;
          src_d       = pick_data;
          we_d        = pick_data & data_we;
          addr_d      = pick_data ? data_addr : inst_addr;
          wdata_d     = pick_data ? data_wdata : '0;
          n_d         = pick_data ? size_bytes(data_size) : 3'd4;
          asm_d       = '0;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = we_d ? wdata_d[7:0] : 8'h00;
        end
      end
      XFER: begin
        if (cnt_q != 3'd0 && !we_q)
          asm_d[{cnt_m1[1:0], 3'b000} +: 8] = mem_rdata;
        if (cnt_q == n_m1) begin
          state_d = DONE;
        end else begin
          cnt_d       = cnt_q + 3'd1;
          mem_en_d    = 1'b1;
          mem_we_d    = we_q;
          mem_addr_d  = addr_q + ADDR_WIDTH'(cnt_d);
          mem_wdata_d = we_q ? wdata_q[{cnt_d[1:0], 3'b000} +: 8]
                             : 8'h00;
        end
      end
      DONE: begin
        state_d = IDLE;
        if (!we_q)
          asm_d[{n_m1[1:0], 3'b000} +: 8] = mem_rdata;
        if (src_q) begin
          data_done_d = 1'b1;
          if (!we_q) data_rdata_d = asm_d;
        end else begin
          inst_done_d  = 1'b1;
          inst_rdata_d = asm_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      n_q          <= '0;
      addr_q       <= '0;
      we_q         <= 1'b0;
      src_q        <= 1'b0;
      wdata_q      <= '0;
      asm_q        <= '0;
      inst_rdata_q <= '0;
      data_rdata_q <= '0;
      inst_done_q  <= 1'b0;
      data_done_q  <= 1'b0;
      mem_en_q     <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      n_q          <= n_d;
      addr_q       <= addr_d;
      we_q         <= we_d;
      src_q        <= src_d;
      wdata_q      <= wdata_d;
      asm_q        <= asm_d;
      inst_rdata_q <= inst_rdata_d;
      data_rdata_q <= data_rdata_d;
      inst_done_q  <= inst_done_d;
      data_done_q  <= data_done_d;
      mem_en_q     <= mem_en_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
    end
  end

  assign inst_rdata = inst_rdata_q;
  assign inst_done  = inst_done_q;
  assign data_rdata = data_rdata_q;
  assign data_done  = data_done_q;
  assign mem_en     = mem_en_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: randomized scoreboard bench for mem_arbiter.
// Honours MEM_ARBITER_RR_EN in its arbitration model.
`timescale 1ns/1ps
module tb_mem_arbiter;

  localparam int AW  = 17;
  localparam int LW  = 32;
  localparam int MSZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          inst_req = 1'b0;
  logic [AW-1:0] inst_addr = '0;
  logic [LW-1:0] inst_rdata;
  logic          inst_done;
  logic          data_req = 1'b0;
  logic          data_we = 1'b0;
  logic [1:0]    data_size = 2'b00;
  logic [AW-1:0] data_addr = '0;
  logic [LW-1:0] data_wdata = '0;
  logic [LW-1:0] data_rdata;
  logic          data_done;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata = 8'h00;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .LEN(LW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .inst_req  (inst_req),
    .inst_addr (inst_addr),
    .inst_rdata(inst_rdata),
    .inst_done (inst_done),
    .data_req  (data_req),
    .data_we   (data_we),
    .data_size (data_size),
    .data_addr (data_addr),
    .data_wdata(data_wdata),
    .data_rdata(data_rdata),
    .data_done (data_done),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  logic [7:0] mem     [0:MSZ-1];
  logic [7:0] ref_mem [0:MSZ-1];

  // Byte memory: synchronous write, one-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) mem[mem_addr] = mem_wdata;
      else        mem_rdata <= mem[mem_addr];
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [AW-1:0] addr;
    bit            we;
    logic [7:0]    wd;
  } acc_t;

  typedef struct {
    bit            is_data;
    bit            we;
    int            n;
    logic [LW-1:0] rd;
  } txn_t;

  acc_t          exp_acc[$];
  txn_t          exp_txn[$];
  int            checks = 0;
  int            errors = 0;
  logic [LW-1:0] m_inst_rd = '0;
  logic [LW-1:0] m_data_rd = '0;
  bit            m_last_data = 1'b0;
  int            grant_cyc = 0;
  bit            prev_en = 1'b0;

  function automatic bit model_pick_data(input bit i, input bit d);
    if (!d) return 1'b0;
    if (!i) return 1'b1;
`ifdef MEM_ARBITER_RR_EN
    return !m_last_data;
`else
    return 1'b1;
`endif
  endfunction

  // Reference: one granted transaction as a list of byte accesses.
  task automatic push_txn(input bit is_data, input bit we,
                          input logic [1:0] size,
                          input logic [AW-1:0] addr,
                          input logic [LW-1:0] wd);
    txn_t t;
    acc_t a;
    logic [AW-1:0] ba;
    t.is_data = is_data;
    t.we = is_data && we;
    if (!is_data)          t.n = 4;
    else if (size == 2'b00) t.n = 1;
    else if (size == 2'b01) t.n = 2;
    else                    t.n = 4;
    t.rd = '0;
    for (int i = 0; i < t.n; i++) begin
      ba = addr + AW'(i);
      a.addr = ba;
      a.we = t.we;
      a.wd = t.we ? wd[8*i +: 8] : 8'h00;
      exp_acc.push_back(a);
      if (t.we) ref_mem[ba] = wd[8*i +: 8];
      else      t.rd[8*i +: 8] = ref_mem[ba];
    end
    exp_txn.push_back(t);
    m_last_data = is_data;
  endtask

  task automatic chk_zero(input string nm);
    checks++;
    if ({inst_done, data_done, mem_en, mem_we, mem_addr, mem_wdata,
         inst_rdata, data_rdata} !== '0)
      begin
        errors++;
        $display("FAIL %s outputs not zero: done=%b%b en=%b we=%b a=%h wd=%h ird=%h drd=%h",
                 nm, inst_done, data_done, mem_en, mem_we, mem_addr,
                 mem_wdata, inst_rdata, data_rdata);
      end
  endtask

  // Drive until `want` completions, releasing each requester on its done.
  task automatic run(input int want, input bit keep,
                     input bit scr, input bit drop);
    int dn = 0;
    int budget = 100;
    bit seen = 1'b0;
    while (dn < want && budget > 0) begin
      @(negedge clk);
      budget--;
      if (mem_en && !seen) begin
        seen = 1'b1;
        if (scr) begin
          inst_addr  = AW'($urandom);
          data_addr  = AW'($urandom);
          data_we    = 1'($urandom_range(0, 1));
          data_size  = 2'($urandom_range(0, 3));
          data_wdata = $urandom;
          if (drop) begin
            inst_req = 1'b0;
            data_req = 1'b0;
          end
        end
      end
      if (inst_done || data_done) begin
        dn++;
        if (!keep) begin
          if (inst_done) inst_req = 1'b0;
          if (data_done) data_req = 1'b0;
        end
      end
    end
    inst_req = 1'b0;
    data_req = 1'b0;
    checks++;
    if (dn < want) begin
      errors++;
      $display("FAIL timeout completions got %0d want %0d", dn, want);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic single(input bit is_data, input bit we,
                        input logic [1:0] size,
                        input logic [AW-1:0] addr,
                        input logic [LW-1:0] wd,
                        input bit scr, input bit drop);
    @(negedge clk);
    inst_req   = !is_data;
    data_req   = is_data;
    inst_addr  = addr;
    data_addr  = addr;
    data_we    = we;
    data_size  = size;
    data_wdata = wd;
    push_txn(is_data, we, size, addr, wd);
    run(1, 1'b0, scr, drop);
  endtask

  task automatic both(input logic [AW-1:0] ia, input bit we,
                      input logic [1:0] size,
                      input logic [AW-1:0] da,
                      input logic [LW-1:0] wd);
    bit w;
    @(negedge clk);
    inst_req   = 1'b1;
    data_req   = 1'b1;
    inst_addr  = ia;
    data_addr  = da;
    data_we    = we;
    data_size  = size;
    data_wdata = wd;
    w = model_pick_data(1'b1, 1'b1);
    if (w) begin
      push_txn(1'b1, we, size, da, wd);
      push_txn(1'b0, 1'b0, 2'b10, ia, '0);
    end else begin
      push_txn(1'b0, 1'b0, 2'b10, ia, '0);
      push_txn(1'b1, we, size, da, wd);
    end
    run(2, 1'b0, 1'b0, 1'b0);
  endtask

  // Monitor: checks every bus cycle and every completion in order.
  initial begin : monitor
    txn_t t;
    acc_t a;
    int lat;
    logic [LW-1:0] got;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_en = 1'b0;
      end else begin
        checks++;
        if (mem_en) begin
          if (!prev_en) grant_cyc = cyc;
          if (exp_acc.size() == 0) begin
            errors++;
            $display("FAIL mem_acc unexpected addr=%h we=%b", mem_addr, mem_we);
          end else begin
            a = exp_acc.pop_front();
            if (mem_addr !== a.addr || mem_we !== a.we ||
                (a.we && mem_wdata !== a.wd)) begin
              errors++;
              $display("FAIL mem_acc got a=%h we=%b wd=%h want a=%h we=%b wd=%h",
                       mem_addr, mem_we, mem_wdata, a.addr, a.we, a.wd);
            end
          end
        end else if (mem_we !== 1'b0 || mem_addr !== '0 ||
                     mem_wdata !== 8'h00) begin
          errors++;
          $display("FAIL mem_idle got we=%b a=%h wd=%h want 0",
                   mem_we, mem_addr, mem_wdata);
        end
        prev_en = mem_en;
        if (inst_done || data_done) begin
          checks++;
          if (inst_done && data_done) begin
            errors++;
            $display("FAIL done both pulses high");
          end else if (exp_txn.size() == 0) begin
            errors++;
            $display("FAIL done unexpected inst=%b data=%b", inst_done, data_done);
          end else begin
            t = exp_txn.pop_front();
            lat = cyc - grant_cyc + 1;
            got = t.is_data ? data_rdata : inst_rdata;
            if (data_done !== t.is_data || lat != t.n + 2 ||
                (!t.we && got !== t.rd)) begin
              errors++;
              $display("FAIL txn got data=%b lat=%0d rd=%h want data=%b lat=%0d rd=%h",
                       data_done, lat, got, t.is_data, t.n + 2, t.rd);
            end
            if (!t.we) begin
              if (t.is_data) m_data_rd = t.rd;
              else           m_inst_rd = t.rd;
            end
          end
        end
        checks++;
        if (inst_rdata !== m_inst_rd || data_rdata !== m_data_rd) begin
          errors++;
          $display("FAIL rdata_hold got i=%h d=%h want i=%h d=%h",
                   inst_rdata, data_rdata, m_inst_rd, m_data_rd);
        end
      end
    end
  end

  initial begin : driver
    logic [7:0]    b;
    logic [AW-1:0] ra;
    acc_t          a;
    int            k;
    int            n;
    int            budget;
    for (int i = 0; i < MSZ; i++) begin
      b = 8'($urandom);
      mem[i] = b;
      ref_mem[i] = b;
    end
    repeat (3) @(negedge clk);
    chk_zero("reset");
    #2 rst_n = 1'b1;

    mem[17'h10] = 8'h13; ref_mem[17'h10] = 8'h13;
    mem[17'h11] = 8'h05; ref_mem[17'h11] = 8'h05;
    mem[17'h12] = 8'h10; ref_mem[17'h12] = 8'h10;
    mem[17'h13] = 8'h00; ref_mem[17'h13] = 8'h00;
    single(1'b0, 1'b0, 2'b10, 17'h00010, '0, 1'b0, 1'b0);
    single(1'b1, 1'b1, 2'b10, 17'h1FFFE, 32'hDEADBEEF, 1'b0, 1'b0);
    single(1'b1, 1'b0, 2'b10, 17'h1FFFE, '0, 1'b0, 1'b0);
    mem[17'h3] = 8'h80; ref_mem[17'h3] = 8'h80;
    single(1'b1, 1'b0, 2'b00, 17'h00003, '0, 1'b0, 1'b0);
    single(1'b1, 1'b0, 2'b01, 17'h00003, '0, 1'b0, 1'b0);
    single(1'b1, 1'b0, 2'b11, 17'h00101, '0, 1'b0, 1'b0);
    single(1'b1, 1'b1, 2'b10, 17'h00200, 32'h11223344, 1'b1, 1'b1);
    single(1'b0, 1'b0, 2'b00, 17'h00200, '0, 1'b1, 1'b0);

    @(negedge clk);
    inst_req   = 1'b1;
    data_req   = 1'b1;
    inst_addr  = 17'h00010;
    data_addr  = 17'h00200;
    data_we    = 1'b0;
    data_size  = 2'b10;
    for (int g = 0; g < 4; g++) begin
      if (model_pick_data(1'b1, 1'b1))
        push_txn(1'b1, 1'b0, 2'b10, 17'h00200, '0);
      else
        push_txn(1'b0, 1'b0, 2'b10, 17'h00010, '0);
    end
    run(4, 1'b1, 1'b0, 1'b0);

    ra = 17'h00300;
    @(negedge clk);
    data_req   = 1'b1;
    data_we    = 1'b1;
    data_size  = 2'b10;
    data_addr  = ra;
    data_wdata = 32'hCAFEF00D;
    for (int i = 0; i < 2; i++) begin
      a.addr = ra + AW'(i);
      a.we = 1'b1;
      a.wd = (i == 0) ? 8'h0D : 8'hF0;
      exp_acc.push_back(a);
    end
    ref_mem[ra] = 8'h0D;
    n = 0;
    budget = 20;
    while (n < 2 && budget > 0) begin
      @(negedge clk);
      budget--;
      if (mem_en) n++;
    end
    checks++;
    if (n < 2) begin
      errors++;
      $display("FAIL reset_setup xfer cycles got %0d want 2", n);
    end
    #2 rst_n = 1'b0;
    data_req = 1'b0;
    exp_acc.delete();
    exp_txn.delete();
    m_inst_rd = '0;
    m_data_rd = '0;
    m_last_data = 1'b0;
    @(negedge clk);
    chk_zero("reset_mid");
    @(negedge clk);
    #2 rst_n = 1'b1;
    checks++;
    if (mem[ra] !== 8'h0D || mem[ra + 17'd1] !== ref_mem[ra + 17'd1]) begin
      errors++;
      $display("FAIL reset_abort mem got %h %h want %h %h",
               mem[ra], mem[ra + 17'd1], 8'h0D, ref_mem[ra + 17'd1]);
    end
    single(1'b1, 1'b0, 2'b10, ra, '0, 1'b0, 1'b0);

    for (int r = 0; r < 40; r++) begin
      k = $urandom_range(0, 2);
      if (k == 2)
        both(AW'($urandom), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), AW'($urandom), $urandom);
      else
        single(k == 1, 1'($urandom_range(0, 1)),
               2'($urandom_range(0, 3)), AW'($urandom), $urandom,
               1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0);
    end

    checks++;
    if (exp_txn.size() != 0 || exp_acc.size() != 0) begin
      errors++;
      $display("FAIL leftover txn=%0d acc=%0d want 0 0",
               exp_txn.size(), exp_acc.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
